// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// - uart_rx_ctrl_state_t : sequencing FSM states of uart_rx_ctrl
// - RX_CTRL_ARM / RX_CTRL_FIN : bit indices within the rx_ctrl control bus
// - ctrl_for_state() : control-line levels to drive while in a given state
package uart_pkg;

  typedef enum logic [2:0] {
    StWait,
    StCapt,
    StFinHi,
    StFinLo,
    StArmHi,
    StArmLo,
    StPark
  } uart_rx_ctrl_state_t;

  localparam int unsigned RX_CTRL_ARM = 0;
  localparam int unsigned RX_CTRL_FIN = 1;

  function automatic logic [1:0] ctrl_for_state(uart_rx_ctrl_state_t s);
    logic [1:0] ctrl;
    ctrl = 2'b00;
    if (s == StFinHi) ctrl[RX_CTRL_FIN] = 1'b1;
    if (s == StArmHi) ctrl[RX_CTRL_ARM] = 1'b1;
    return ctrl;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the UART receive controller and the CPU-side consumer.
// Circular buffer with a registered head byte.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   push/din : write request and byte (ignored when full unless popping too)
//   pop/dout : read request (ignored when empty) and registered head byte
//   level    : occupancy, full/empty : occupancy flags
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q, rptr_d;
  logic [PtrW:0]   count_q;
  logic [7:0]      dout_q;
  logic            push_eff, pop_eff;

  assign full  = (count_q == (PtrW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // A push into a full FIFO still lands if the same cycle frees a slot.
  assign push_eff = push & (~full | pop);
  assign pop_eff  = pop & ~empty;
  assign rptr_d   = pop_eff ? rptr_q + PtrW'(1) : rptr_q;

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      if (push_eff) wptr_q <= wptr_q + PtrW'(1);
      rptr_q <= rptr_d;
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
      // Head register: bypass din when the new head slot is being written now.
      if (pop_eff || (push_eff && empty)) begin
        dout_q <= (push_eff && (wptr_q == rptr_d)) ? din : mem_q[rptr_d];
      end
    end
  end

  assign dout  = dout_q;
  assign level = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencing controller for the UART receiver.
// After each received byte it pulses the finish line, then (if enabled) the re-arm
// line, drains the byte into a FIFO and offers it on a valid/ready read port.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   en                       : keep re-arming the receiver after each byte
//   rx_data_valid, rx_data   : completed byte from the receiver
//   rx_ready                 : receiver idle (status only, not used for sequencing)
//   rx_ctrl                  : registered control levels, [0]=re-arm, [1]=finish
//   rd_valid/rd_data/rd_ready: consumer read port
//   level                    : FIFO occupancy
//   overrun / clr_ovr        : sticky dropped-byte flag and its clear
//   busy                     : sequence in progress (not in WAIT or PARK)
//   ovr_cnt                  : saturating drop count, only with UART_RX_CTRL_OVR_CNT_EN
module uart_rx_ctrl import uart_pkg::*; #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PULSE_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   rx_data_valid,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ready,
  output logic [1:0]             rx_ctrl,
  output logic                   rd_valid,
  output logic [7:0]             rd_data,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  input  logic                   clr_ovr,
  output logic                   busy
`ifdef UART_RX_CTRL_OVR_CNT_EN
  ,
  output logic [7:0]             ovr_cnt
`endif
);

  localparam int unsigned CntW = $clog2(PULSE_W) + 1;
  localparam logic [CntW-1:0] CntReload = CntW'(PULSE_W - 1);

  uart_rx_ctrl_state_t state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                disarmed_q, disarmed_d;
  logic [1:0]          rx_ctrl_q;
  logic                overrun_q, overrun_d;
  logic                phase_done, capt, pop, drop;
  logic                fifo_full, fifo_empty;
  logic                unused_rx_ready;

  assign unused_rx_ready = rx_ready;

  assign phase_done = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    disarmed_d = disarmed_q;
    unique case (state_q)
      StWait: begin
        if (rx_data_valid) state_d = StCapt;
        else if (!en)      state_d = StPark;
      end
      StCapt:  state_d = StFinHi;
      StFinHi: if (phase_done) state_d = StFinLo;
      StFinLo: begin
        if (phase_done) begin
          disarmed_d = 1'b1;
          state_d    = en ? StArmHi : StPark;
        end
      end
      StArmHi: if (phase_done) state_d = StArmLo;
      StArmLo: begin
        if (phase_done) begin
          disarmed_d = 1'b0;
          state_d    = StWait;
        end
      end
      StPark: begin
        // Only re-arm if we were the ones who finished the receiver.
        if (en) state_d = disarmed_q ? StArmHi : StWait;
      end
      default: state_d = StWait;
    endcase

    if (state_d != state_q) cnt_d = CntReload;
    else if (phase_done)    cnt_d = cnt_q;
    else                    cnt_d = cnt_q - CntW'(1);
  end

  assign capt      = (state_q == StCapt);
  assign pop       = rd_ready & ~fifo_empty;
  assign drop      = capt & fifo_full & ~pop;
  assign overrun_d = drop | (overrun_q & ~clr_ovr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWait;
      cnt_q      <= CntReload;
      disarmed_q <= 1'b0;
      rx_ctrl_q  <= 2'b00;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      disarmed_q <= disarmed_d;
      // Decoded from the next state so the line moves on the state-change edge.
      rx_ctrl_q  <= ctrl_for_state(state_d);
      overrun_q  <= overrun_d;
    end
  end

`ifdef UART_RX_CTRL_OVR_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (drop) begin
      if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end else if (clr_ovr) begin
      ovr_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovr_cnt_q <= 8'd0;
    else     ovr_cnt_q <= ovr_cnt_d;
  end

  assign ovr_cnt = ovr_cnt_q;
`endif

  uart_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capt),
    .din   (rx_data),
    .pop   (pop),
    .dout  (rd_data),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_ctrl  = rx_ctrl_q;
  assign rd_valid = ~fifo_empty;
  assign overrun  = overrun_q;
  assign busy     = (state_q != StWait) && (state_q != StPark);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DEPTH=8, PULSE_W=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, rx_data_valid, rx_ready, rd_ready, clr_ovr;
  logic [7:0] rx_data, rd_data;
  logic [1:0] rx_ctrl;
  logic       rd_valid, overrun, busy;
  logic [3:0] level;
`ifdef UART_RX_CTRL_OVR_CNT_EN
  logic [7:0] ovr_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DEPTH   (8),
    .PULSE_W (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .rx_data_valid (rx_data_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .rx_ctrl       (rx_ctrl),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_ready      (rd_ready),
    .level         (level),
    .overrun       (overrun),
    .clr_ovr       (clr_ovr),
    .busy          (busy)
`ifdef UART_RX_CTRL_OVR_CNT_EN
    ,
    .ovr_cnt       (ovr_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One byte from the receiver, then wait until the FSM is back in WAIT (1 + 4*2 + 1 edges).
  task automatic send(input logic [7:0] b);
    rx_data_valid = 1'b1;
    rx_data       = b;
    step(1);
    rx_data_valid = 1'b0;
    step(9);
  endtask

  logic [1:0] exp_seq [7] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};

  initial begin
    rst = 1'b1; en = 1'b0; rx_data_valid = 1'b0; rx_data = 8'h00;
    rx_ready = 1'b1; rd_ready = 1'b0; clr_ovr = 1'b0;
    step(2);
    chk("rst_rx_ctrl", rx_ctrl, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_level", level, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
`ifdef UART_RX_CTRL_OVR_CNT_EN
    chk("rst_ovr_cnt", ovr_cnt, 0);
`endif
    rst = 1'b0;
    en  = 1'b1;

    // Single byte with full control-line sequence
    rx_data_valid = 1'b1; rx_data = 8'hA5;
    step(1);
    rx_data_valid = 1'b0;
    chk("sb_capt_busy", busy, 1);
    chk("sb_capt_rd_valid", rd_valid, 0);
    chk("sb_capt_rx_ctrl", rx_ctrl, 0);
    step(1);
    chk("sb_rd_valid", rd_valid, 1);
    chk("sb_rd_data", rd_data, 8'hA5);
    chk("sb_fin_rise", rx_ctrl, 2'b10);
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk($sformatf("sb_seq%0d", i), rx_ctrl, exp_seq[i]);
    end
    step(1);
    chk("sb_idle_busy", busy, 0);
    chk("sb_idle_rx_ctrl", rx_ctrl, 0);
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
    chk("sb_pop_level", level, 0);
    chk("sb_pop_rd_valid", rd_valid, 0);

    // Fill to full, overrun on the ninth byte, drain in order
    for (int i = 0; i < 8; i++) send(8'(i));
    chk("fill_level", level, 8);
    chk("fill_head", rd_data, 8'h00);
    chk("fill_no_ovr", overrun, 0);
    send(8'hFF);
    chk("ovr_flag", overrun, 1);
    chk("ovr_level", level, 8);
`ifdef UART_RX_CTRL_OVR_CNT_EN
    chk("ovr_cnt_one", ovr_cnt, 1);
`endif
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_valid%0d", i), rd_valid, 1);
      chk($sformatf("drain_data%0d", i), rd_data, 32'(i));
      step(1);
    end
    rd_ready = 1'b0;
    chk("drain_level", level, 0);
    chk("drain_empty", rd_valid, 0);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    chk("clr_ovr", overrun, 0);
`ifdef UART_RX_CTRL_OVR_CNT_EN
    chk("clr_ovr_cnt", ovr_cnt, 0);
`endif

    // Push and pop together while full
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    rx_data_valid = 1'b1; rx_data = 8'h55;
    step(1);
    rx_data_valid = 1'b0;
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
    chk("pp_level", level, 8);
    chk("pp_no_ovr", overrun, 0);
    chk("pp_head", rd_data, 8'h11);
    step(8);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_data%0d", i), rd_data, (i < 7) ? 32'h11 + 32'(i) : 32'h55);
      step(1);
    end
    rd_ready = 1'b0;
    chk("pp_drain_level", level, 0);

    // Disable during FIN_HI: park without a re-arm pulse, re-arm on enable
    rx_data_valid = 1'b1; rx_data = 8'h77;
    step(1);
    rx_data_valid = 1'b0;
    step(1);
    chk("dis_fin_hi", rx_ctrl, 2'b10);
    en = 1'b0;
    step(4);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("park_ctrl%0d", i), rx_ctrl, 0);
      chk($sformatf("park_busy%0d", i), busy, 0);
      step(1);
    end
    en = 1'b1;
    step(1);
    chk("unpark_arm0", rx_ctrl, 2'b01);
    chk("unpark_busy", busy, 1);
    step(1);
    chk("unpark_arm1", rx_ctrl, 2'b01);
    step(1);
    chk("unpark_lo0", rx_ctrl, 0);
    step(1);
    chk("unpark_lo1", rx_ctrl, 0);
    step(1);
    chk("unpark_wait", busy, 0);
    chk("dis_data", rd_data, 8'h77);
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;

    // Park from WAIT with the receiver still armed: no re-arm pulse on enable
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(1);
    chk("park_wait_no_arm", rx_ctrl, 0);

    // Reset during ARM_HI
    rx_data_valid = 1'b1; rx_data = 8'h99;
    step(1);
    rx_data_valid = 1'b0;
    step(5);
    chk("rah_arm", rx_ctrl, 2'b01);
    chk("rah_level", level, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rah_rx_ctrl", rx_ctrl, 0);
    chk("rah_level0", level, 0);
    chk("rah_rd_valid", rd_valid, 0);
    chk("rah_busy", busy, 0);
    chk("rah_rd_data", rd_data, 0);
    rx_data_valid = 1'b1; rx_data = 8'h3C;
    step(1);
    rx_data_valid = 1'b0;
    step(1);
    chk("rah_new_valid", rd_valid, 1);
    chk("rah_new_data", rd_data, 8'h3C);
    chk("rah_new_fin", rx_ctrl, 2'b10);
    step(8);
    chk("rah_new_idle", busy, 0);
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;

    // Drop and clr_ovr in the same cycle: set wins
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
    chk("col_pre_ovr", overrun, 0);
    rx_data_valid = 1'b1; rx_data = 8'hEE;
    step(1);
    rx_data_valid = 1'b0;
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    chk("col_ovr", overrun, 1);
    chk("col_level", level, 8);
    chk("col_head", rd_data, 8'h20);
    step(8);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    chk("col_clr", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
